// File: rtl/main_control_fsm.sv
// Multi-cycle MIPS main control unit. Moore sequencer from fetch through
// writeback. The only input-qualified outputs are the FETCH IR/PC load enables
// and the done pulse of a store, which all wait for the memory handshake.
module main_control_fsm #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                Zero,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          PCSource,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic                instr_done,
    output logic                illegal_op
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB,
        S_MEM_ADDR, S_MEM_RD, S_MEM_WR, S_MEM_WB, S_BRANCH, S_JUMP, S_ILLEGAL
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'('b000000);
    localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'('b100011);
    localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'('b101011);
    localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'('b000100);
    localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'('b000010);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'('b001000);
    localparam logic [OPCODE_W-1:0] OP_ANDI = OPCODE_W'('b001100);
    localparam logic [OPCODE_W-1:0] OP_ORI  = OPCODE_W'('b001101);
    localparam logic [OPCODE_W-1:0] OP_SLTI = OPCODE_W'('b001010);

    localparam logic [ALUOP_W-1:0] ALU_R   = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(5);

    state_t               state, state_nx;
    // Instruction class captured in DECODE so later states never look at Opcode.
    logic [ALUOP_W-1:0]   i_aluop, i_aluop_nx;
    logic                 mem_is_lw;

    // The branch decision is made in the datapath (PCWriteCond & Zero).
    logic zero_unused;
    assign zero_unused = Zero;

    // Immediate-class ALU operation picked from the opcode.
    always_comb begin
        i_aluop_nx = ALU_ADD;
        case (Opcode)
            OP_ANDI: i_aluop_nx = ALU_AND;
            OP_ORI:  i_aluop_nx = ALU_OR;
            OP_SLTI: i_aluop_nx = ALU_SLT;
            default: i_aluop_nx = ALU_ADD;
        endcase
    end

    // State register plus the opcode-class latch loaded in DECODE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            i_aluop   <= ALU_R;
            mem_is_lw <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_DECODE) begin
                i_aluop   <= i_aluop_nx;
                mem_is_lw <= (Opcode == OP_LW);
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:     state_nx = S_FETCH;
            S_FETCH:    if (mem_ready) state_nx = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_R:                              state_nx = S_R_EXEC;
                    OP_LW, OP_SW:                      state_nx = S_MEM_ADDR;
                    OP_BEQ:                            state_nx = S_BRANCH;
                    OP_J:                              state_nx = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_nx = S_I_EXEC;
                    default:                           state_nx = S_ILLEGAL;
                endcase
            end
            S_R_EXEC:   state_nx = S_R_WB;
            S_I_EXEC:   state_nx = S_I_WB;
            S_MEM_ADDR: state_nx = mem_is_lw ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) state_nx = S_MEM_WB;
            S_MEM_WR:   if (mem_ready) state_nx = S_FETCH;
            S_R_WB, S_I_WB, S_MEM_WB, S_BRANCH, S_JUMP: state_nx = S_FETCH;
            S_ILLEGAL:  state_nx = S_ILLEGAL;
            default:    state_nx = S_IDLE;
        endcase
    end

    // Output decode; everything defaults to the idle (all-zero) value.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        ALUOp       = ALU_R;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                ALUSrcB = 2'b01;
                ALUOp   = ALU_ADD;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                ALUOp   = ALU_ADD;
            end
            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_R;
            end
            S_R_WB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_I_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = i_aluop;
            end
            S_I_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = ALU_ADD;
            end
            S_MEM_RD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            S_MEM_WB: begin
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                IorD       = 1'b1;
                MemWrite   = 1'b1;
                instr_done = mem_ready;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
            end
            S_ILLEGAL:  illegal_op = 1'b1;
            default: ;
        endcase
    end

endmodule
